issue_rat_freelist_ckpt: RTL and testbench

Parametrised successor of the issue-stage RAT free list. It holds free physical register tags in a circular FIFO and hands them out one per cycle to rename. Committed tags return on the redeem port. Per-FGR (speculation group) checkpoints of the read pointer let an abandon roll back every tag acquired under that group and all younger groups in one cycle. The block sits between rename/RAT and the retire/redeem path.

---
 rtl/issue_rat_pkg.sv | 18 +
 rtl/issue_rat_fgr_ckpt.sv | 99 +++++++++
 rtl/issue_rat_freelist_ckpt.sv | 120 ++++++++++++
 tb/tb_issue_rat_freelist_ckpt.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/issue_rat_pkg.sv
// Shared definitions for the issue-stage RAT free list with FGR checkpoints.
// Holds the default configuration (64 physical, 32 architectural registers,
// 8 speculation groups) and the widths and types derived from it.
package issue_rat_pkg;

  localparam int unsigned PRF_COUNT_DEFAULT  = 64;
  localparam int unsigned ARCH_COUNT_DEFAULT = 32;
  localparam int unsigned FGR_COUNT_DEFAULT  = 8;

  localparam int unsigned PRF_W = $clog2(PRF_COUNT_DEFAULT);
  localparam int unsigned FGR_W = $clog2(FGR_COUNT_DEFAULT);
  // Pointer carries one extra wrap bit to tell full from empty.
  localparam int unsigned PTR_W = PRF_W + 1;

  typedef logic [PTR_W-1:0]             ptr_t;
  typedef logic [FGR_COUNT_DEFAULT-1:0] fgr_mask_t;

endpackage

// File: rtl/issue_rat_fgr_ckpt.sv
// Checkpoint table for the free-list read pointer, one slot per speculation
// group (FGR). Tracks which groups are open and, per group, which groups
// were already open when it was created, so abandoning a group also drops
// every younger group.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   create_i               speculative acquire handshake this cycle
//   create_fgr_i           group of that acquire
//   create_ptr_i           read pointer before the acquire increments it
//   commit_valid_i/fgr_i   commit strobe and group
//   abandon_valid_i/fgr_i  abandon strobe and group
//   restore_valid_o        abandon hits an open group; rd_ptr must roll back
//   restore_ptr_o          checkpointed read pointer of the abandoned group
module issue_rat_fgr_ckpt
  import issue_rat_pkg::*;
#(
  parameter int unsigned FGR_COUNT = FGR_COUNT_DEFAULT,
  parameter int unsigned FGR_WIDTH = FGR_W,
  parameter int unsigned PTR_WIDTH = PTR_W
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 create_i,
  input  logic [FGR_WIDTH-1:0] create_fgr_i,
  input  logic [PTR_WIDTH-1:0] create_ptr_i,
  input  logic                 commit_valid_i,
  input  logic [FGR_WIDTH-1:0] commit_fgr_i,
  input  logic                 abandon_valid_i,
  input  logic [FGR_WIDTH-1:0] abandon_fgr_i,
  output logic                 restore_valid_o,
  output logic [PTR_WIDTH-1:0] restore_ptr_o
);

  logic [PTR_WIDTH-1:0] ckpt_ptr_q   [FGR_COUNT];
  logic [PTR_WIDTH-1:0] ckpt_ptr_d   [FGR_COUNT];
  logic [FGR_COUNT-1:0] older_mask_q [FGR_COUNT];
  logic [FGR_COUNT-1:0] older_mask_d [FGR_COUNT];
  logic [FGR_COUNT-1:0] ckpt_valid_q;
  logic [FGR_COUNT-1:0] ckpt_valid_d;

  logic create_ok;
  logic commit_ok;

  assign restore_valid_o = abandon_valid_i && ckpt_valid_q[abandon_fgr_i];
  assign restore_ptr_o   = ckpt_ptr_q[abandon_fgr_i];

  // A commit on the same group in the same cycle cancels the new checkpoint.
  assign create_ok = create_i && !ckpt_valid_q[create_fgr_i] &&
                     !(commit_valid_i && (commit_fgr_i == create_fgr_i));
  // Abandon of the same group wins over the commit.
  assign commit_ok = commit_valid_i && ckpt_valid_q[commit_fgr_i] &&
                     !(restore_valid_o && (abandon_fgr_i == commit_fgr_i));

  always_comb begin
    ckpt_ptr_d   = ckpt_ptr_q;
    older_mask_d = older_mask_q;
    ckpt_valid_d = ckpt_valid_q;

    if (create_ok) begin
      ckpt_ptr_d[create_fgr_i]   = create_ptr_i;
      ckpt_valid_d[create_fgr_i] = 1'b1;
      older_mask_d[create_fgr_i] = ckpt_valid_q;
    end

    // Applied after create so a fresh mask never names a retiring group.
    if (commit_ok) begin
      ckpt_valid_d[commit_fgr_i] = 1'b0;
      for (int unsigned j = 0; j < FGR_COUNT; j++) begin
        older_mask_d[j][commit_fgr_i] = 1'b0;
      end
    end

    // Drop the abandoned group and every group opened after it.
    if (restore_valid_o) begin
      for (int unsigned j = 0; j < FGR_COUNT; j++) begin
        if ((FGR_WIDTH'(j) == abandon_fgr_i) || older_mask_q[j][abandon_fgr_i]) begin
          ckpt_valid_d[j] = 1'b0;
          older_mask_d[j] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned j = 0; j < FGR_COUNT; j++) begin
        ckpt_ptr_q[j]   <= '0;
        older_mask_q[j] <= '0;
      end
      ckpt_valid_q <= '0;
    end else begin
      ckpt_ptr_q   <= ckpt_ptr_d;
      older_mask_q <= older_mask_d;
      ckpt_valid_q <= ckpt_valid_d;
    end
  end

endmodule

// File: rtl/issue_rat_freelist_ckpt.sv
// Issue-stage RAT free list: circular FIFO of free physical register tags
// with show-ahead acquire, a redeem (return) port, and per-FGR read-pointer
// checkpoints so an abandon rolls back every tag acquired under that group
// and all younger groups in one cycle.
//
// Ports:
//   clk, resetn                         clock, asynchronous active-low reset
//   i_redeemed_prf/valid, o_redeemed_ready   tag return handshake
//   o_acquire_prf/valid, i_acquire_ready     head tag handshake
//   i_acquire_fgr, i_acquire_fgr_speculative group of the acquire
//   i_commit_fgr/valid                  group commit strobe
//   i_abandon_fgr/valid                 group abandon strobe
//   o_free_count                        free tags (wr_ptr - rd_ptr)
module issue_rat_freelist_ckpt
  import issue_rat_pkg::*;
#(
  parameter int unsigned PRF_COUNT  = PRF_COUNT_DEFAULT,
  parameter int unsigned ARCH_COUNT = ARCH_COUNT_DEFAULT,
  parameter int unsigned FGR_COUNT  = FGR_COUNT_DEFAULT,
  localparam int unsigned PrfW = $clog2(PRF_COUNT),
  localparam int unsigned FgrW = $clog2(FGR_COUNT),
  localparam int unsigned PtrW = PrfW + 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [PrfW-1:0] i_redeemed_prf,
  input  logic            i_redeemed_valid,
  output logic            o_redeemed_ready,
  output logic [PrfW-1:0] o_acquire_prf,
  output logic            o_acquire_valid,
  input  logic [FgrW-1:0] i_acquire_fgr,
  input  logic            i_acquire_fgr_speculative,
  input  logic            i_acquire_ready,
  input  logic [FgrW-1:0] i_commit_fgr,
  input  logic            i_commit_valid,
  input  logic [FgrW-1:0] i_abandon_fgr,
  input  logic            i_abandon_valid,
  output logic [PtrW-1:0] o_free_count
);

  localparam int unsigned InitFree = PRF_COUNT - ARCH_COUNT;

  logic [PrfW-1:0] mem_q [PRF_COUNT];
  logic [PrfW-1:0] mem_d [PRF_COUNT];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;

  logic            empty;
  logic            full;
  logic            acquire_fire;
  logic            redeem_fire;
  logic            restore_valid;
  logic [PtrW-1:0] restore_ptr;

  assign empty = (rd_ptr_q == wr_ptr_q);
  // Full: same slot index, opposite wrap bit.
  assign full  = ((rd_ptr_q ^ wr_ptr_q) == {1'b1, {PrfW{1'b0}}});

  // An abandon blocks acquire so no tag is handed out from a pointer
  // that is about to be rolled back.
  assign o_acquire_valid  = !empty && !i_abandon_valid;
  assign o_acquire_prf    = mem_q[rd_ptr_q[PrfW-1:0]];
  assign o_redeemed_ready = !full;
  assign o_free_count     = wr_ptr_q - rd_ptr_q;

  assign acquire_fire = o_acquire_valid && i_acquire_ready;
  assign redeem_fire  = i_redeemed_valid && o_redeemed_ready;

  issue_rat_fgr_ckpt #(
    .FGR_COUNT (FGR_COUNT),
    .FGR_WIDTH (FgrW),
    .PTR_WIDTH (PtrW)
  ) u_fgr_ckpt (
    .clk_i           (clk),
    .rst_ni          (resetn),
    .create_i        (acquire_fire && i_acquire_fgr_speculative),
    .create_fgr_i    (i_acquire_fgr),
    .create_ptr_i    (rd_ptr_q),
    .commit_valid_i  (i_commit_valid),
    .commit_fgr_i    (i_commit_fgr),
    .abandon_valid_i (i_abandon_valid),
    .abandon_fgr_i   (i_abandon_fgr),
    .restore_valid_o (restore_valid),
    .restore_ptr_o   (restore_ptr)
  );

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    if (redeem_fire) begin
      mem_d[wr_ptr_q[PrfW-1:0]] = i_redeemed_prf;
      wr_ptr_d                  = wr_ptr_q + PtrW'(1);
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    if (restore_valid) begin
      rd_ptr_d = restore_ptr;
    end else if (acquire_fire) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // Tags below ARCH_COUNT hold the reset architectural mapping.
      for (int unsigned i = 0; i < PRF_COUNT; i++) begin
        mem_q[i] <= (i < InitFree) ? PrfW'(ARCH_COUNT + i) : '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= PtrW'(InitFree);
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

endmodule

// File: tb/tb_issue_rat_freelist_ckpt.sv
// Bench for issue_rat_freelist_ckpt (default 64/32/8 configuration).
// Each table row is one cycle of stimulus plus the outputs expected while
// that stimulus is applied; rows with rst=1 pulse the asynchronous reset.
module tb_issue_rat_freelist_ckpt;
  import issue_rat_pkg::*;

  typedef struct {
    bit               rst;
    bit               red_v;
    logic [PRF_W-1:0] red_prf;
    bit               rdy;
    bit               spec;
    logic [FGR_W-1:0] fgr;
    bit               com_v;
    logic [FGR_W-1:0] com_fgr;
    bit               ab_v;
    logic [FGR_W-1:0] ab_fgr;
    bit               e_av;
    logic [PRF_W-1:0] e_prf;
    bit               e_rr;
    ptr_t             e_cnt;
  } vec_t;

  logic             clk;
  logic             resetn;
  logic [PRF_W-1:0] i_redeemed_prf;
  logic             i_redeemed_valid;
  logic             o_redeemed_ready;
  logic [PRF_W-1:0] o_acquire_prf;
  logic             o_acquire_valid;
  logic [FGR_W-1:0] i_acquire_fgr;
  logic             i_acquire_fgr_speculative;
  logic             i_acquire_ready;
  logic [FGR_W-1:0] i_commit_fgr;
  logic             i_commit_valid;
  logic [FGR_W-1:0] i_abandon_fgr;
  logic             i_abandon_valid;
  logic [PTR_W-1:0] o_free_count;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_tests;
  int   n_fail;

  issue_rat_freelist_ckpt dut (
    .clk                       (clk),
    .resetn                    (resetn),
    .i_redeemed_prf            (i_redeemed_prf),
    .i_redeemed_valid          (i_redeemed_valid),
    .o_redeemed_ready          (o_redeemed_ready),
    .o_acquire_prf             (o_acquire_prf),
    .o_acquire_valid           (o_acquire_valid),
    .i_acquire_fgr             (i_acquire_fgr),
    .i_acquire_fgr_speculative (i_acquire_fgr_speculative),
    .i_acquire_ready           (i_acquire_ready),
    .i_commit_fgr              (i_commit_fgr),
    .i_commit_valid            (i_commit_valid),
    .i_abandon_fgr             (i_abandon_fgr),
    .i_abandon_valid           (i_abandon_valid),
    .o_free_count              (o_free_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input int rst, input int red_v, input int red_prf, input int rdy,
                     input int spec, input int fgr, input int com_v, input int com_fgr,
                     input int ab_v, input int ab_fgr, input int e_av, input int e_prf,
                     input int e_rr, input int e_cnt);
    vec_t v;
    v.rst     = (rst != 0);
    v.red_v   = (red_v != 0);
    v.red_prf = PRF_W'(red_prf);
    v.rdy     = (rdy != 0);
    v.spec    = (spec != 0);
    v.fgr     = FGR_W'(fgr);
    v.com_v   = (com_v != 0);
    v.com_fgr = FGR_W'(com_fgr);
    v.ab_v    = (ab_v != 0);
    v.ab_fgr  = FGR_W'(ab_fgr);
    v.e_av    = (e_av != 0);
    v.e_prf   = PRF_W'(e_prf);
    v.e_rr    = (e_rr != 0);
    v.e_cnt   = PTR_W'(e_cnt);
    vecs.push_back(v);
  endtask

  task automatic t_rst();
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32, 1, 32);
  endtask

  task automatic t_idle(input int av, input int prf, input int rr, input int cnt);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, av, prf, rr, cnt);
  endtask

  task automatic t_acq(input int spec, input int fgr, input int prf, input int rr,
                       input int cnt);
    add(0, 0, 0, 1, spec, fgr, 0, 0, 0, 0, 1, prf, rr, cnt);
  endtask

  task automatic t_ab(input int fgr, input int cnt);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, fgr, 0, 0, 1, cnt);
  endtask

  task automatic chk(input string name, input int row, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0d, expected %0d", name, row, act, exp);
    end
  endtask

  task automatic build();
    // Drain all 32 free tags in order, then redeem into the empty list.
    t_rst();
    for (int i = 0; i < 32; i++) t_acq(0, 0, 32 + i, 1, 32 - i);
    t_idle(0, 0, 1, 0);
    add(0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    t_idle(1, 5, 1, 1);

    // Three speculative acquires under fgr2, then abandon fgr2.
    t_rst();
    t_acq(1, 2, 32, 1, 32);
    t_acq(1, 2, 33, 1, 31);
    t_acq(1, 2, 34, 1, 30);
    t_ab(2, 29);
    t_idle(1, 32, 1, 32);

    // fgr1 then fgr3; abandoning fgr1 also drops the younger fgr3.
    t_rst();
    t_acq(1, 1, 32, 1, 32);
    t_acq(1, 1, 33, 1, 31);
    t_acq(1, 3, 34, 1, 30);
    t_acq(1, 3, 35, 1, 29);
    t_ab(1, 28);
    t_idle(1, 32, 1, 32);
    t_ab(3, 32);
    t_idle(1, 32, 1, 32);

    // Commit fgr1, abandon fgr3 restores to tag 34; fgr1 stays consumed.
    t_rst();
    t_acq(1, 1, 32, 1, 32);
    t_acq(1, 1, 33, 1, 31);
    t_acq(1, 3, 34, 1, 30);
    t_acq(1, 3, 35, 1, 29);
    add(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 36, 1, 28);
    t_ab(3, 28);
    t_idle(1, 34, 1, 30);
    t_ab(1, 30);
    t_idle(1, 34, 1, 30);
    // Commit fgr5 with a speculative acquire on fgr5: no checkpoint made.
    add(0, 0, 0, 1, 1, 5, 1, 5, 0, 0, 1, 34, 1, 30);
    t_ab(5, 29);
    t_idle(1, 35, 1, 29);
    // Commit fgr6 and abandon fgr6 together: abandon wins.
    t_acq(1, 6, 35, 1, 29);
    add(0, 0, 0, 0, 0, 0, 1, 6, 1, 6, 0, 0, 1, 28);
    t_idle(1, 35, 1, 29);
    // Commit fgr4 while abandoning the younger fgr7: both apply.
    t_acq(1, 4, 35, 1, 29);
    t_acq(1, 7, 36, 1, 28);
    add(0, 0, 0, 0, 0, 0, 1, 4, 1, 7, 0, 0, 1, 27);
    t_idle(1, 36, 1, 28);
    t_ab(4, 28);
    t_idle(1, 36, 1, 28);

    // Abandon fgr0 with ready and a redeem of tag 7 in the same cycle.
    t_rst();
    t_acq(1, 0, 32, 1, 32);
    t_acq(1, 0, 33, 1, 31);
    add(0, 1, 7, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 30);
    t_idle(1, 32, 1, 33);
    for (int i = 0; i < 32; i++) t_acq(0, 0, 32 + i, 1, 33 - i);
    t_acq(0, 0, 7, 1, 1);
    t_idle(0, 0, 1, 0);

    // Fill to full, rejected redeem, then acquire plus redeem together.
    t_rst();
    for (int i = 0; i < 32; i++) add(0, 1, i, 0, 0, 0, 0, 0, 0, 0, 1, 32, 1, 32 + i);
    add(0, 1, 9, 0, 0, 0, 0, 0, 0, 0, 1, 32, 0, 64);
    t_idle(1, 32, 0, 64);
    t_acq(0, 0, 32, 0, 64);
    add(0, 1, 11, 1, 0, 0, 0, 0, 0, 0, 1, 33, 1, 63);
    t_idle(1, 34, 1, 63);
    // Reset in the middle of operation restores the image without a clock edge.
    t_rst();
    t_idle(1, 32, 1, 32);
  endtask

  initial begin
    vec_t v;
    vec_t e;
    n_tests                   = 0;
    n_fail                    = 0;
    resetn                    = 1'b1;
    i_redeemed_prf            = '0;
    i_redeemed_valid          = 1'b0;
    i_acquire_fgr             = '0;
    i_acquire_fgr_speculative = 1'b0;
    i_acquire_ready           = 1'b0;
    i_commit_fgr              = '0;
    i_commit_valid            = 1'b0;
    i_abandon_fgr             = '0;
    i_abandon_valid           = 1'b0;
    build();

    for (int r = 0; r < vecs.size(); r++) begin
      v = vecs[r];
      @(negedge clk);
      if (v.rst) resetn = 1'b0;
      i_redeemed_valid          = v.red_v;
      i_redeemed_prf            = v.red_prf;
      i_acquire_ready           = v.rdy;
      i_acquire_fgr_speculative = v.spec;
      i_acquire_fgr             = v.fgr;
      i_commit_valid            = v.com_v;
      i_commit_fgr              = v.com_fgr;
      i_abandon_valid           = v.ab_v;
      i_abandon_fgr             = v.ab_fgr;
      exp_q.push_back(v);
      #1;
      e = exp_q.pop_front();
      chk("acquire_valid", r, int'(o_acquire_valid), int'(e.e_av));
      if (e.e_av) chk("acquire_prf", r, int'(o_acquire_prf), int'(e.e_prf));
      chk("redeemed_ready", r, int'(o_redeemed_ready), int'(e.e_rr));
      chk("free_count", r, int'(o_free_count), int'(e.e_cnt));
      if (v.rst) begin
        #2;
        resetn = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
